score_display_ctrl: RTL and testbench

Sequential controller that accepts a binary score over a valid/ready handshake and converts it to BCD by iterative double-dabble. It holds the committed digits in a display register and drives one 7-segment pattern per digit through instances of the team's `seven_segment` decoder. It sits between the Frogger game-state logic (score/lives counters) and the board HEX outputs, so the game core never performs decimal arithmetic.

---
 rtl/score_pkg.sv | 27 ++
 rtl/seven_segment.sv | 26 ++
 rtl/score_display_ctrl.sv | 124 ++++++++++++
 tb/tb_score_display_ctrl.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/score_pkg.sv
// Shared types and constants for the score display controller.
// Holds the FSM state enum, the blank segment pattern and constant helpers.
package score_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    COMMIT
  } state_t;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Largest value representable in 'digits' decimal digits (10^digits - 1).
  function automatic int unsigned max_score(input int unsigned digits);
    int unsigned p;
    p = 1;
    for (int unsigned i = 0; i < digits; i++) begin
      p = p * 10;
    end
    return p - 1;
  endfunction

  function automatic int cnt_width(input int bin_w);
    return $clog2(bin_w + 1);
  endfunction

endpackage

// File: rtl/seven_segment.sv
// BCD digit to active-low 7-segment pattern; bit 6 = a ... bit 0 = g.
// Codes 10..15 decode to all segments off.
module seven_segment
  import score_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  always_comb begin
    unique case (digit)
      4'd0:    seg = 7'b0000001;
      4'd1:    seg = 7'b1001111;
      4'd2:    seg = 7'b0010010;
      4'd3:    seg = 7'b0000110;
      4'd4:    seg = 7'b1001100;
      4'd5:    seg = 7'b0100100;
      4'd6:    seg = 7'b0100000;
      4'd7:    seg = 7'b0001111;
      4'd8:    seg = 7'b0000000;
      4'd9:    seg = 7'b0000100;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/score_display_ctrl.sv
// Binary score to BCD (iterative double-dabble) with a committed display register
// and per-digit 7-segment decode. Define SCORE_LZB_EN for leading-zero blanking.
module score_display_ctrl
  import score_pkg::*;
#(
  parameter int DIGITS = 4,
  parameter int BIN_W  = 14
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [BIN_W-1:0]      score_in,
  input  logic                  score_valid,
  output logic                  score_ready,
  input  logic                  clr,
  output logic                  busy,
  output logic                  sat,
  output logic [7*DIGITS-1:0]   hex_out
);

  localparam int unsigned MAX_VAL = max_score(DIGITS);
  localparam int          CNT_W   = cnt_width(BIN_W);
  localparam int          BCD_W   = 4 * DIGITS;

  state_t              state, next_state;
  logic                ready_q;
  logic                accept;
  logic                over;
  logic [BIN_W-1:0]    clamped;
  logic [BIN_W-1:0]    bin;
  logic [BCD_W-1:0]    bcd;
  logic [BCD_W-1:0]    bcd_adj;
  logic [BCD_W+BIN_W-1:0] shifted;
  logic [CNT_W-1:0]    cnt;
  logic                sat_pend;
  logic [BCD_W-1:0]    disp;

  // Ready is a registered flag; clr only masks it, so score_valid never feeds back.
  assign score_ready = ready_q & ~clr;
  assign busy        = (state != IDLE);
  assign accept      = (state == IDLE) && score_valid && score_ready;

  assign over    = 32'(score_in) > MAX_VAL;
  assign clamped = over ? BIN_W'(MAX_VAL) : score_in;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      ready_q <= 1'b1;
    end else begin
      state   <= next_state;
      ready_q <= (next_state == IDLE);
    end
  end

  // NOTE: every output of a combinational block gets a default first so no latch is inferred.
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (accept) next_state = CONV;
      CONV:    if (cnt == CNT_W'(BIN_W - 1)) next_state = COMMIT;
      COMMIT:  next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
  end

  assign shifted = {bcd_adj, bin} << 1;

  // NOTE: the conversion datapath has no reset; it is fully reloaded on every handshake
  // and nothing downstream observes it until COMMIT.
  always_ff @(posedge clk) begin
    if (accept) begin
      bin      <= clamped;
      bcd      <= '0;
      cnt      <= '0;
      sat_pend <= over;
    end else if (state == CONV) begin
      bin <= shifted[BIN_W-1:0];
      bcd <= shifted[BCD_W+BIN_W-1:BIN_W];
      cnt <= cnt + 1'b1;
    end
  end

  // Display state changes only at COMMIT, at clr in IDLE, or at reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      disp <= '0;
      sat  <= 1'b0;
    end else if (state == COMMIT) begin
      disp <= bcd;
      sat  <= sat_pend;
    end else if (state == IDLE && clr) begin
      disp <= '0;
      sat  <= 1'b0;
    end
  end

  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    logic [6:0] seg_raw;

    seven_segment u_seg (
      .digit (disp[4*i +: 4]),
      .seg   (seg_raw)
    );

`ifdef SCORE_LZB_EN
    if (i == 0) begin : g_keep
      assign hex_out[7*i +: 7] = seg_raw;
    end else begin : g_blank
      // Blank when this digit and every more significant digit are zero.
      assign hex_out[7*i +: 7] = (disp[BCD_W-1:4*i] == '0) ? SEG_BLANK : seg_raw;
    end
`else
    assign hex_out[7*i +: 7] = seg_raw;
`endif
  end

endmodule

// File: tb/tb_score_display_ctrl.sv
// Self-checking bench for score_display_ctrl: decimal-level reference model compared
// every cycle, plus directed scenarios with hand-computed literal expectations.
module tb_score_display_ctrl;

  localparam int DIGITS = 4;
  localparam int BIN_W  = 14;
  localparam int unsigned MAXV = 9999;

`ifdef SCORE_LZB_EN
  localparam bit LZB = 1'b1;
  localparam logic [27:0] HEX_ZERO = {7'b1111111, 7'b1111111, 7'b1111111, 7'b0000001};
  localparam logic [27:0] HEX_5    = {7'b1111111, 7'b1111111, 7'b1111111, 7'b0100100};
  localparam logic [27:0] HEX_88   = {7'b1111111, 7'b1111111, 7'b0000000, 7'b0000000};
  localparam logic [27:0] HEX_7    = {7'b1111111, 7'b1111111, 7'b1111111, 7'b0001111};
`else
  localparam bit LZB = 1'b0;
  localparam logic [27:0] HEX_ZERO = {4{7'b0000001}};
  localparam logic [27:0] HEX_5    = {7'b0000001, 7'b0000001, 7'b0000001, 7'b0100100};
  localparam logic [27:0] HEX_88   = {7'b0000001, 7'b0000001, 7'b0000000, 7'b0000000};
  localparam logic [27:0] HEX_7    = {7'b0000001, 7'b0000001, 7'b0000001, 7'b0001111};
`endif
  localparam logic [27:0] HEX_1234 = {7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100};
  localparam logic [27:0] HEX_9999 = {4{7'b0000100}};

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic [BIN_W-1:0]     score_in = '0;
  logic                 score_valid = 1'b0;
  logic                 score_ready;
  logic                 clr = 1'b0;
  logic                 busy;
  logic                 sat;
  logic [7*DIGITS-1:0]  hex_out;

  score_display_ctrl #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .score_in    (score_in),
    .score_valid (score_valid),
    .score_ready (score_ready),
    .clr         (clr),
    .busy        (busy),
    .sat         (sat),
    .hex_out     (hex_out)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;
  bit cmp_en = 1'b0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: decimal value on display, pending score and cycles left until commit.
  int unsigned m_disp = 0, m_pend = 0;
  bit          m_sat = 1'b0, m_pend_sat = 1'b0;
  int          m_left = 0;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_disp = 0; m_sat = 1'b0; m_left = 0;
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0) begin
        m_disp = m_pend;
        m_sat  = m_pend_sat;
      end
    end else if (clr) begin
      m_disp = 0; m_sat = 1'b0;
    end else if (score_valid) begin
      m_pend_sat = (int'(score_in) > int'(MAXV));
      m_pend     = m_pend_sat ? MAXV : int'(score_in);
      m_left     = BIN_W + 1;
    end
  end

  function automatic logic [6:0] seg_of(input int unsigned d);
    case (d)
      0: return 7'b0000001;  1: return 7'b1001111;
      2: return 7'b0010010;  3: return 7'b0000110;
      4: return 7'b1001100;  5: return 7'b0100100;
      6: return 7'b0100000;  7: return 7'b0001111;
      8: return 7'b0000000;  default: return 7'b0000100;
    endcase
  endfunction

  function automatic logic [7*DIGITS-1:0] exp_hex(input int unsigned v);
    logic [7*DIGITS-1:0] r;
    int unsigned pw;
    pw = 1;
    for (int i = 0; i < DIGITS; i++) begin
      if (LZB && i > 0 && v < pw) r[7*i +: 7] = 7'b1111111;
      else                        r[7*i +: 7] = seg_of((v / pw) % 10);
      pw = pw * 10;
    end
    return r;
  endfunction

  always @(negedge clk) begin
    if (cmp_en) begin
      check("cmp_ready", 32'(score_ready), 32'((m_left == 0) && !clr));
      check("cmp_busy",  32'(busy),        32'(m_left > 0));
      check("cmp_sat",   32'(sat),         32'(m_sat));
      check("cmp_hex",   32'(hex_out),     32'(exp_hex(m_disp)));
    end
  end

  // Called at posedge+1; returns at posedge+1 just after the accepting edge.
  task automatic send(input int unsigned v, output int acc_cyc);
    bit rdy;
    int n;
    n = 0;
    score_in    = BIN_W'(v);
    score_valid = 1'b1;
    do begin
      @(negedge clk);
      rdy = score_ready;
      @(posedge clk);
      n++;
    end while (!rdy && n < 200);
    #1;
    acc_cyc     = cyc;
    score_valid = 1'b0;
    if (!rdy) check("send_timeout", 32'(n), 32'(0));
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy && n < 100);
    if (busy) check("idle_timeout", 32'(n), 32'(0));
    @(posedge clk);
    #1;
  endtask

  initial begin
    int c0, c1, lat;

    repeat (3) @(posedge clk);
    #1;
    rst_n  = 1'b1;
    cmp_en = 1'b1;
    @(negedge clk);
    check("rst_hex",   32'(hex_out),     32'(HEX_ZERO));
    check("rst_ready", 32'(score_ready), 32'd1);
    check("rst_busy",  32'(busy),        32'd0);
    check("rst_sat",   32'(sat),         32'd0);
    @(posedge clk);
    #1;

    // 1234: latency and digit patterns
    send(1234, c0);
    lat = 0;
    do begin
      @(negedge clk);
      if (busy) lat++;
    end while (busy && lat < 100);
    check("latency_1234", 32'(lat), 32'd15);
    @(posedge clk);
    #1;
    check("hex_1234", 32'(hex_out), 32'(HEX_1234));
    check("sat_1234", 32'(sat),     32'd0);

    // 16383 clamps to 9999, then clr in IDLE
    send(16383, c0);
    wait_idle();
    check("hex_9999", 32'(hex_out), 32'(HEX_9999));
    check("sat_9999", 32'(sat),     32'd1);
    clr = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
    check("clr_hex", 32'(hex_out), 32'(HEX_ZERO));
    check("clr_sat", 32'(sat),     32'd0);

    // 5: leading digits blanked or zero depending on build
    send(5, c0);
    wait_idle();
    check("hex_5", 32'(hex_out), 32'(HEX_5));

    // 42 then 7 held during CONV: 7 accepted 16 edges later
    send(42, c0);
    repeat (3) @(posedge clk);
    #1;
    send(7, c1);
    check("gap_42_7", 32'(c1 - c0), 32'd16);
    wait_idle();
    check("hex_7", 32'(hex_out), 32'(HEX_7));

    // clr and valid together: clr wins, 88 accepted the next cycle
    clr         = 1'b1;
    score_valid = 1'b1;
    score_in    = BIN_W'(88);
    @(negedge clk);
    check("clr_blocks_ready", 32'(score_ready), 32'd0);
    @(posedge clk);
    #1;
    clr = 1'b0;
    c0  = cyc;
    check("clr88_hex", 32'(hex_out), 32'(HEX_ZERO));
    send(88, c1);
    check("accept_88_next", 32'(c1 - c0), 32'd1);
    wait_idle();
    check("hex_88", 32'(hex_out), 32'(HEX_88));

    // Reset at E8 of a 999 conversion
    send(999, c0);
    repeat (7) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_mid_ready", 32'(score_ready), 32'd1);
    check("rst_mid_busy",  32'(busy),        32'd0);
    check("rst_mid_hex",   32'(hex_out),     32'(HEX_ZERO));
    repeat (20) @(posedge clk);
    #1;
    check("no_999_hex", 32'(hex_out), 32'(HEX_ZERO));

    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
